// File: rtl/indexed_mem_access.sv
// indexed_mem_access
// Multi-cycle load/store sequencer for register-indirect accesses with optional
// pre/post increment/decrement of the pointer register.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start                request a new access (sampled only while idle)
//   is_store, is_byte    access kind: store/load, byte/word
//   upd, pre, dec        pointer update enable, pre-modify, decrement
//   ptr_in, wdata        pointer register value, store data
//   mem_req/we/be/addr/wdata, mem_ack, mem_rdata   data-memory req/ack port
//   rdata                last load result
//   ptr_out, ptr_we      updated pointer value and one-cycle write-back pulse
//   busy, done           not-idle flag, one-cycle completion pulse
//   fault                alignment fault pulse (ALIGN_CHECK_EN builds only)
//
// Build option: define ALIGN_CHECK_EN to trap word accesses at odd addresses
// instead of silently truncating them to the enclosing aligned word.

module indexed_mem_access #(
  parameter int unsigned WORD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_store,
  input  logic            is_byte,
  input  logic            upd,
  input  logic            pre,
  input  logic            dec,
  input  logic [WORD-1:0] ptr_in,
  input  logic [WORD-1:0] wdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [1:0]      mem_be,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [WORD-1:0] mem_rdata,
  output logic [WORD-1:0] rdata,
  output logic [WORD-1:0] ptr_out,
  output logic            ptr_we,
  output logic            busy,
  output logic            done
`ifdef ALIGN_CHECK_EN
  ,
  output logic            fault
`endif
);

`ifdef ALIGN_CHECK_EN
  typedef enum logic [1:0] {StIdle, StReq, StWb, StFlt} state_e;
`else
  typedef enum logic [1:0] {StIdle, StReq, StWb} state_e;
`endif

  state_e          r_state;
  state_e          w_state_d;

  logic            r_is_store;
  logic            r_is_byte;
  logic            r_upd;
  logic [WORD-1:0] r_ea;
  logic [WORD-1:0] r_wdata;
  logic [WORD-1:0] r_rdata;
  logic [WORD-1:0] r_ptr_out;

  logic [WORD-1:0] w_step;
  logic [WORD-1:0] w_mod;
  logic [WORD-1:0] w_ea;
  logic [WORD-1:0] w_ptr_new;
  logic [WORD-1:0] w_load_data;
  logic            w_accept;

  // Address arithmetic on the live request inputs; wraps modulo 2^WORD.
  always_comb begin
    w_step    = is_byte ? WORD'(1) : WORD'(2);
    w_mod     = dec ? (ptr_in - w_step) : (ptr_in + w_step);
    w_ea      = (upd && pre) ? w_mod : ptr_in;
    w_ptr_new = upd ? w_mod : ptr_in;
    w_accept  = (r_state == StIdle) && start;
  end

  // Byte loads pick the lane selected by the low address bit, zero-extended.
  always_comb begin
    w_load_data = mem_rdata;
    if (r_is_byte) begin
      w_load_data = {8'h00, (r_ea[0] ? mem_rdata[15:8] : mem_rdata[7:0])};
    end
  end

  // Next-state logic and decoded outputs.
  always_comb begin
    w_state_d = r_state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    ptr_we    = 1'b0;
    done      = 1'b0;
    busy      = (r_state != StIdle);
`ifdef ALIGN_CHECK_EN
    fault     = 1'b0;
`endif
    case (r_state)
      StIdle: begin
        if (start) begin
`ifdef ALIGN_CHECK_EN
          if (!is_byte && w_ea[0]) begin
            w_state_d = StFlt;
          end else begin
            w_state_d = StReq;
          end
`else
          w_state_d = StReq;
`endif
        end
      end
      StReq: begin
        mem_req   = 1'b1;
        mem_we    = r_is_store;
        // Word accesses drop address bit 0 and enable both lanes.
        mem_addr  = {r_ea[WORD-1:1], 1'b0};
        mem_be    = r_is_byte ? (r_ea[0] ? 2'b10 : 2'b01) : 2'b11;
        mem_wdata = r_is_byte ? {r_wdata[7:0], r_wdata[7:0]} : r_wdata;
        if (mem_ack) begin
          w_state_d = StWb;
        end
      end
      StWb: begin
        done      = 1'b1;
        ptr_we    = r_upd;
        w_state_d = StIdle;
      end
`ifdef ALIGN_CHECK_EN
      StFlt: begin
        done      = 1'b1;
        fault     = 1'b1;
        w_state_d = StIdle;
      end
`endif
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_is_store <= 1'b0;
      r_is_byte  <= 1'b0;
      r_upd      <= 1'b0;
      r_ea       <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_ptr_out  <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_is_store <= is_store;
        r_is_byte  <= is_byte;
        r_upd      <= upd;
        r_ea       <= w_ea;
        r_wdata    <= wdata;
        r_ptr_out  <= w_ptr_new;
      end
      if ((r_state == StReq) && mem_ack && !r_is_store) begin
        r_rdata <= w_load_data;
      end
    end
  end

  assign rdata   = r_rdata;
  assign ptr_out = r_ptr_out;

endmodule
